// File: rtl/fp_pkg.sv
// Shared single-precision constants and enums for the FP multiply responder.
package fp_pkg;

  localparam int          EXP_BIAS    = 127;
  localparam logic [31:0] FP_QNAN     = 32'h7FC0_0000;
  localparam logic [31:0] FP_POS_INF  = 32'h7F80_0000;
  localparam logic [31:0] FP_NEG_INF  = 32'hFF80_0000;
  localparam logic [31:0] FP_POS_ZERO = 32'h0000_0000;
  localparam logic [31:0] FP_NEG_ZERO = 32'h8000_0000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_UNPACK,
    ST_MULT,
    ST_NORM,
    ST_DONE
  } fp_mult_state_t;

  typedef enum logic [1:0] {
    CLS_ZERO,
    CLS_INF,
    CLS_NAN,
    CLS_NORMAL
  } fp_class_t;

endpackage

// File: rtl/fp_mult_responder_if.sv
// Start/ready handshake bundle between the term accumulator and the FP multiplier.
interface fp_mult_responder_if
  import fp_pkg::*;
#(
  parameter int DATA_WIDTH = 32
);
  logic                  mult_start;
  logic [DATA_WIDTH-1:0] operand_a;
  logic [DATA_WIDTH-1:0] operand_b;
  logic [DATA_WIDTH-1:0] mult_result;
  logic                  mult_data_ready;
  logic                  busy;

  modport master (
    output mult_start, operand_a, operand_b,
    input  mult_result, mult_data_ready, busy
  );

  modport slave (
    input  mult_start, operand_a, operand_b,
    output mult_result, mult_data_ready, busy
  );
endinterface

// File: rtl/seq_mantissa_multiplier.sv
// Fixed-latency shift-add mantissa multiplier: one partial product per cycle.
// done_o is high during the final step; product_o is complete from the next cycle.
module seq_mantissa_multiplier #(
  parameter int MANTISSA_LEN = 23
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            start_i,
  input  logic [MANTISSA_LEN:0]           mant_a_i,
  input  logic [MANTISSA_LEN:0]           mant_b_i,
  output logic [2*(MANTISSA_LEN+1)-1:0]   product_o,
  output logic                            done_o
);
  localparam int MW = MANTISSA_LEN + 1;
  localparam int PW = 2 * MW;
  localparam int CW = $clog2(MW);
  localparam logic [CW-1:0] LAST = CW'(MW - 1);

  logic [CW-1:0] cnt_q;
  logic          active_q;
  logic [PW-1:0] mcand_q;
  logic [MW-1:0] mplier_q;
  logic [PW-1:0] prod_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q    <= '0;
      active_q <= 1'b0;
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
    end else if (start_i) begin
      cnt_q    <= '0;
      active_q <= 1'b1;
      mcand_q  <= {{MW{1'b0}}, mant_a_i};
      mplier_q <= mant_b_i;
      prod_q   <= '0;
    end else if (active_q) begin
      prod_q   <= prod_q + (mplier_q[0] ? mcand_q : '0);
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + 1'b1;
      if (cnt_q == LAST) active_q <= 1'b0;
    end
  end

  assign product_o = prod_q;
  assign done_o    = active_q && (cnt_q == LAST);

endmodule

// File: rtl/fp_mult_responder.sv
// IEEE-754 multiply responder: latches operands on start, runs a fixed-latency
// mantissa multiply, and returns a truncated packed product with a ready pulse.
//
// state  | meaning
// IDLE   | waiting for mult_start; operands latched on start
// UNPACK | classify operands, sum exponents, launch mantissa multiplier
// MULT   | shift-add steps, one per cycle, fixed count
// NORM   | normalise, apply special cases, register packed result
// DONE   | result and ready pulse visible for one cycle
module fp_mult_responder
  import fp_pkg::*;
#(
  parameter int EXP_LEN      = 8,
  parameter int MANTISSA_LEN = 23,
  parameter int DATA_WIDTH   = 1 + EXP_LEN + MANTISSA_LEN
) (
  input logic                clock,
  input logic                reset,
  fp_mult_responder_if.slave bus
);
  localparam int MW = MANTISSA_LEN + 1;
  localparam int PW = 2 * MW;
  localparam int EW = EXP_LEN + 2;
  localparam logic signed [EW-1:0] BIAS    = EW'((1 << (EXP_LEN - 1)) - 1);
  localparam logic signed [EW-1:0] EXP_TOP = EW'((1 << EXP_LEN) - 1);

  function automatic fp_class_t classify(input logic [EXP_LEN-1:0] e,
                                         input logic [MANTISSA_LEN-1:0] f);
    if (e == '0) return CLS_ZERO;
    if (&e) return (f == '0) ? CLS_INF : CLS_NAN;
    return CLS_NORMAL;
  endfunction

  fp_mult_state_t          state_q, state_d;
  logic [DATA_WIDTH-1:0]   op_a_q, op_b_q;
  logic [DATA_WIDTH-1:0]   result_q, result_d;
  logic                    ready_q, busy_q;
  logic                    sign_q;
  fp_class_t               cls_a_q, cls_b_q;
  logic signed [EW-1:0]    exp_q;

  logic [EXP_LEN-1:0]      ea, eb;
  logic [MANTISSA_LEN-1:0] fa, fb;
  logic                    mul_start, mul_done;
  logic [PW-1:0]           product;

  logic signed [EW-1:0]    exp_fin;
  logic [MANTISSA_LEN-1:0] frac;
  logic                    any_nan, any_inf, any_zero;
  logic [DATA_WIDTH-1:0]   norm_word;
  logic                    unused_low_bits;

  assign ea = op_a_q[DATA_WIDTH-2 -: EXP_LEN];
  assign eb = op_b_q[DATA_WIDTH-2 -: EXP_LEN];
  assign fa = op_a_q[MANTISSA_LEN-1:0];
  assign fb = op_b_q[MANTISSA_LEN-1:0];

  seq_mantissa_multiplier #(.MANTISSA_LEN(MANTISSA_LEN)) u_mul (
    .clock     (clock),
    .reset     (reset),
    .start_i   (mul_start),
    .mant_a_i  ({1'b1, fa}),
    .mant_b_i  ({1'b1, fb}),
    .product_o (product),
    .done_o    (mul_done)
  );

  // Truncating normalisation; special cases override in priority order.
  always_comb begin
    exp_fin   = exp_q + {{(EW-1){1'b0}}, product[PW-1]};
    frac      = product[PW-1] ? product[PW-2 -: MANTISSA_LEN]
                              : product[PW-3 -: MANTISSA_LEN];
    any_nan   = (cls_a_q == CLS_NAN)  || (cls_b_q == CLS_NAN);
    any_inf   = (cls_a_q == CLS_INF)  || (cls_b_q == CLS_INF);
    any_zero  = (cls_a_q == CLS_ZERO) || (cls_b_q == CLS_ZERO);
    norm_word = {sign_q, exp_fin[EXP_LEN-1:0], frac};
    if (any_nan || (any_inf && any_zero))
      norm_word = {1'b0, {EXP_LEN{1'b1}}, 1'b1, {(MANTISSA_LEN-1){1'b0}}};
    else if (any_inf)
      norm_word = {sign_q, {EXP_LEN{1'b1}}, {MANTISSA_LEN{1'b0}}};
    else if (any_zero)
      norm_word = {sign_q, {(DATA_WIDTH-1){1'b0}}};
    else if (exp_fin >= EXP_TOP)
      norm_word = {sign_q, {EXP_LEN{1'b1}}, {MANTISSA_LEN{1'b0}}};
    else if (exp_fin[EW-1] || (exp_fin == '0))
      norm_word = {sign_q, {(DATA_WIDTH-1){1'b0}}};
  end

  assign unused_low_bits = ^product[PW-MANTISSA_LEN-3:0];

  always_comb begin
    state_d   = state_q;
    mul_start = 1'b0;
    result_d  = '0;
    case (state_q)
      ST_IDLE:   if (bus.mult_start) state_d = ST_UNPACK;
      ST_UNPACK: begin
        mul_start = 1'b1;
        state_d   = ST_MULT;
      end
      ST_MULT:   if (mul_done) state_d = ST_NORM;
      ST_NORM: begin
        result_d = norm_word;
        state_d  = ST_DONE;
      end
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      result_q <= '0;
      ready_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      ready_q  <= (state_q == ST_NORM);
      busy_q   <= (state_d != ST_IDLE);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      op_a_q  <= '0;
      op_b_q  <= '0;
      sign_q  <= 1'b0;
      cls_a_q <= CLS_ZERO;
      cls_b_q <= CLS_ZERO;
      exp_q   <= '0;
    end else begin
      if ((state_q == ST_IDLE) && bus.mult_start) begin
        op_a_q <= bus.operand_a;
        op_b_q <= bus.operand_b;
      end
      if (state_q == ST_UNPACK) begin
        sign_q  <= op_a_q[DATA_WIDTH-1] ^ op_b_q[DATA_WIDTH-1];
        cls_a_q <= classify(ea, fa);
        cls_b_q <= classify(eb, fb);
        exp_q   <= $signed({2'b00, ea}) + $signed({2'b00, eb}) - BIAS;
      end
    end
  end

  assign bus.mult_result     = result_q;
  assign bus.mult_data_ready = ready_q;
  assign bus.busy            = busy_q;

endmodule
